spi_sample_rx: RTL and testbench

- SPI slave receiver that takes the GPS sample stream the bridge sends to the MCU (MCU_SCK / MCU_SS / MCU_MOSI) and turns it back into 2-bit I / 2-bit Q sample pairs.
- Runs entirely in the MCU_CLK_25_000 domain and oversamples the serial lines.
- Used as the loopback checker in bridge benches, and as the receive front end for MCU-side emulation on the CPLD.

---
 rtl/spi_sample_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_sample_rx.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sample_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_sample_rx
// Purpose  : SPI slave receiver for the GPS sample stream sent by the bridge to
//            the MCU. It oversamples SCK/SS/MOSI in the MCU_CLK_25_000 domain,
//            assembles MSB-first bytes, buffers them in a small FIFO, and
//            unpacks each byte into two {I1,I0,Q1,Q0} samples (upper nibble
//            first) behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   MCU_CLK_25_000  in   system clock (25.000 MHz)
//   RESET           in   asynchronous active-high reset
//   MCU_SCK         in   SPI clock, idles low, data sampled on rising edge
//   MCU_SS          in   SPI slave select, active low
//   MCU_MOSI        in   SPI data, MSB first
//   SAMPLE_I        out  {I1,I0} of the current sample
//   SAMPLE_Q        out  {Q1,Q0} of the current sample
//   SAMPLE_VALID    out  SAMPLE_I/SAMPLE_Q hold a valid sample
//   SAMPLE_READY    in   consumer accepts the sample (VALID & READY)
//   FRAME_ERR       out  one-cycle pulse when SS deasserts mid-byte
//   OVERFLOW        out  sticky: a completed byte was dropped (FIFO full)
//   FIFO_LEVEL      out  bytes in the FIFO, excluding the unpacker's byte
// ============================================================================
module spi_sample_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          MCU_CLK_25_000,
    input  logic                          RESET,
    input  logic                          MCU_SCK,
    input  logic                          MCU_SS,
    input  logic                          MCU_MOSI,
    output logic [1:0]                    SAMPLE_I,
    output logic [1:0]                    SAMPLE_Q,
    output logic                          SAMPLE_VALID,
    input  logic                          SAMPLE_READY,
    output logic                          FRAME_ERR,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    DEPTH_LV = (PTR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchronizers. SS resets high so a reset never looks like the
    // start of a frame.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   ss_d;

    always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
        if (RESET) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], MCU_SCK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], MCU_SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MCU_MOSI};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_rise;
    logic ss_rise;
    logic ss_fall;
    logic sample_edge;

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_d;
    assign ss_rise     = ss_s & ~ss_d;
    assign ss_fall     = ~ss_s & ss_d;
    assign sample_edge = sck_rise & ~ss_s;

    // ------------------------------------------------------------------
    // Shift register / bit counter. Only seven bits are stored: the eighth
    // bit goes straight into the FIFO write data, so the byte lands in the
    // FIFO at the end of the same edge cycle.
    // ------------------------------------------------------------------
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       frame_err;
    logic       byte_done;
    logic [7:0] byte_data;

    assign byte_done = sample_edge & (bit_cnt == 3'd7) & ~ss_fall;
    assign byte_data = {shreg, mosi_s};

    always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
        if (RESET) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (ss_rise) begin
                // Partial byte is discarded; flag only if bits were taken.
                bit_cnt   <= '0;
                frame_err <= (bit_cnt != 3'd0);
            end else if (ss_fall) begin
                bit_cnt <= '0;
            end else if (sample_edge) begin
                shreg   <= {shreg[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;      // 7 -> 0 on byte completion
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO. A write into a full FIFO is still accepted when the
    // unpacker pops in the same cycle.
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;
    logic             overflow;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             wr_ok;

    assign fifo_full  = (level == DEPTH_LV);
    assign fifo_empty = (level == '0);
    assign wr_ok      = byte_done & (~fifo_full | pop);

    always_ff @(posedge MCU_CLK_25_000) begin
        if (wr_ok) begin
            mem[wr_ptr] <= byte_data;
        end
    end

    always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
            if (byte_done && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Unpacker FSM: upper nibble first, then lower nibble. Popping from LO
    // straight into HI keeps one sample per cycle with READY held high.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] held;

    always_ff @(posedge MCU_CLK_25_000 or posedge RESET) begin
        if (RESET) begin
            state <= ST_EMPTY;
            held  <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                held <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        next_state   = state;
        pop          = 1'b0;
        SAMPLE_VALID = 1'b0;
        SAMPLE_I     = 2'b00;
        SAMPLE_Q     = 2'b00;
        case (state)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_HI;
                end
            end
            ST_HI: begin
                SAMPLE_VALID = 1'b1;
                {SAMPLE_I, SAMPLE_Q} = held[7:4];
                if (SAMPLE_READY) begin
                    next_state = ST_LO;
                end
            end
            ST_LO: begin
                SAMPLE_VALID = 1'b1;
                {SAMPLE_I, SAMPLE_Q} = held[3:0];
                if (SAMPLE_READY) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = ST_HI;
                    end else begin
                        next_state = ST_EMPTY;
                    end
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    assign FRAME_ERR  = frame_err;
    assign OVERFLOW   = overflow;
    assign FIFO_LEVEL = level;

endmodule
`default_nettype wire

// File: tb/tb_spi_sample_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sample_rx
// Purpose  : Self-checking bench for spi_sample_rx. Expected samples are
//            pushed to a scoreboard queue when bytes are sent and popped by a
//            monitor whenever the DUT completes a VALID & READY handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sample_rx;

    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       rst;
    logic       sck;
    logic       ss;
    logic       mosi;
    logic [1:0] sample_i;
    logic [1:0] sample_q;
    logic       sample_valid;
    logic       sample_ready;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_level;

    int         checks   = 0;
    int         failures = 0;
    int         fe_count = 0;
    logic [3:0] sb [$];
    logic [3:0] exp_nib;

    spi_sample_rx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .MCU_CLK_25_000(clk),
        .RESET         (rst),
        .MCU_SCK       (sck),
        .MCU_SS        (ss),
        .MCU_MOSI      (mosi),
        .SAMPLE_I      (sample_i),
        .SAMPLE_Q      (sample_q),
        .SAMPLE_VALID  (sample_valid),
        .SAMPLE_READY  (sample_ready),
        .FRAME_ERR     (frame_err),
        .OVERFLOW      (overflow),
        .FIFO_LEVEL    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every accepted sample must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_count++;
            if (sample_valid && sample_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sample_unexpected got I=%0d Q=%0d, none expected",
                             sample_i, sample_q);
                end else begin
                    exp_nib = sb.pop_front();
                    if ({sample_i, sample_q} !== exp_nib) begin
                        failures++;
                        $display("FAIL sample_value got I=%0d Q=%0d expected I=%0d Q=%0d",
                                 sample_i, sample_q, exp_nib[3:2], exp_nib[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the top n bits of data MSB first; SCK ends low after 4 clocks.
    task automatic send_bits(input logic [7:0] data, input int n);
        for (int k = 7; k > 7 - n; k--) begin
            mosi = data[k];
            sck  = 1'b0;
            tick(4);
            sck  = 1'b1;
            tick(4);
        end
        sck = 1'b0;
        tick(4);
    endtask

    task automatic push_byte(input logic [7:0] b);
        sb.push_back(b[7:4]);
        sb.push_back(b[3:0]);
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) tick(1);
        tick(4);
    endtask

    task automatic test_reset;
        rst = 1'b1; sck = 1'b0; ss = 1'b1; mosi = 1'b0; sample_ready = 1'b0;
        tick(3);
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if ({sample_valid, sample_i, sample_q} !== 5'b0) begin
                failures++;
                $display("FAIL reset_sample pass=%0d got %b expected 00000", pass,
                         {sample_valid, sample_i, sample_q});
            end
            checks++;
            if ({frame_err, overflow, fifo_level} !== 5'b0) begin
                failures++;
                $display("FAIL reset_flags pass=%0d got %b expected 00000", pass,
                         {frame_err, overflow, fifo_level});
            end
            rst = 1'b0;
            tick(3);
        end
    endtask

    task automatic test_single_byte;
        sample_ready = 1'b1;
        ss = 1'b0;
        tick(4);
        send_bits(8'hA5, 7);
        mosi = 1'b1;
        tick(1);
        push_byte(8'hA5);
        sck = 1'b1;                          // bit-8 SCK rise
        repeat (4) @(negedge clk);           // E+1
        checks++;
        if (sample_valid !== 1'b0 || fifo_level !== 3'd1) begin
            failures++;
            $display("FAIL latency_fifo got valid=%b level=%0d expected valid=0 level=1",
                     sample_valid, fifo_level);
        end
        @(negedge clk);                      // E+2
        checks++;
        if (sample_valid !== 1'b1 || sample_i !== 2'b10 || sample_q !== 2'b10) begin
            failures++;
            $display("FAIL latency_first got valid=%b I=%0d Q=%0d expected valid=1 I=2 Q=2",
                     sample_valid, sample_i, sample_q);
        end
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b1 || sample_i !== 2'b01 || sample_q !== 2'b01) begin
            failures++;
            $display("FAIL second_sample got valid=%b I=%0d Q=%0d expected valid=1 I=1 Q=1",
                     sample_valid, sample_i, sample_q);
        end
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL single_idle got valid=%b level=%0d expected valid=0 level=0",
                     sample_valid, fifo_level);
        end
        sck = 1'b0;
        tick(4);
        ss = 1'b1;
        tick(4);
    endtask

    task automatic test_back_to_back;
        int fe0;
        fe0 = fe_count;
        sample_ready = 1'b1;
        ss = 1'b0;
        tick(4);
        push_byte(8'h3C);
        send_bits(8'h3C, 8);
        push_byte(8'hF0);
        send_bits(8'hF0, 8);
        wait_drain(100);
        ss = 1'b1;
        tick(6);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL b2b_drain got %0d pending expected 0", sb.size());
        end
        checks++;
        if (fe_count !== fe0) begin
            failures++;
            $display("FAIL b2b_frame_err got %0d pulses expected 0", fe_count - fe0);
        end
    endtask

    task automatic test_frame_error;
        int fe0;
        fe0 = fe_count;
        sample_ready = 1'b1;
        ss = 1'b0;
        tick(4);
        send_bits(8'hFF, 5);
        ss = 1'b1;
        tick(8);
        checks++;
        if (fe_count !== fe0 + 1) begin
            failures++;
            $display("FAIL frame_err_pulse got %0d cycles expected 1", fe_count - fe0);
        end
        checks++;
        if (sample_valid !== 1'b0 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL frame_err_nodata got valid=%b level=%0d expected 0 0",
                     sample_valid, fifo_level);
        end
        ss = 1'b0;
        tick(4);
        push_byte(8'h81);
        send_bits(8'h81, 8);
        wait_drain(100);
        ss = 1'b1;
        tick(6);
        checks++;
        if (sb.size() !== 0 || fe_count !== fe0 + 1) begin
            failures++;
            $display("FAIL frame_err_recover got pending=%0d pulses=%0d expected 0 1",
                     sb.size(), fe_count - fe0);
        end
    endtask

    task automatic test_overflow;
        sample_ready = 1'b0;
        ss = 1'b0;
        tick(4);
        for (int b = 0; b < FIFO_DEPTH + 2; b++) begin
            if (b < FIFO_DEPTH + 1) push_byte(8'(b));
            send_bits(8'(b), 8);
        end
        tick(4);
        checks++;
        if (fifo_level !== 3'd4) begin
            failures++;
            $display("FAIL ovf_level got %0d expected 4", fifo_level);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got %b expected 1", overflow);
        end
        checks++;
        if (sample_valid !== 1'b1 || {sample_i, sample_q} !== 4'h0) begin
            failures++;
            $display("FAIL ovf_hold got valid=%b I=%0d Q=%0d expected 1 0 0",
                     sample_valid, sample_i, sample_q);
        end
        sample_ready = 1'b1;
        wait_drain(100);
        ss = 1'b1;
        tick(4);
        checks++;
        if (sb.size() !== 0 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL ovf_drain got pending=%0d level=%0d expected 0 0",
                     sb.size(), fifo_level);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got %b expected 1", overflow);
        end
    endtask

    task automatic test_ss_high;
        int fe0;
        fe0 = fe_count;
        sample_ready = 1'b1;
        ss = 1'b1;
        tick(4);
        send_bits(8'hFF, 8);
        send_bits(8'hFF, 8);
        checks++;
        if (dut.bit_cnt !== 3'd0) begin
            failures++;
            $display("FAIL ss_high_bitcnt got %0d expected 0", dut.bit_cnt);
        end
        checks++;
        if (fe_count !== fe0 || sample_valid !== 1'b0 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL ss_high_quiet got pulses=%0d valid=%b level=%0d expected 0 0 0",
                     fe_count - fe0, sample_valid, fifo_level);
        end
    endtask

    task automatic test_reset_midframe;
        sample_ready = 1'b0;
        ss = 1'b0;
        tick(4);
        mosi = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sck = 1'b0; tick(4);
            sck = 1'b1; tick(4);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sample_valid, sample_i, sample_q, frame_err, overflow, fifo_level} !== 10'b0
            || dut.bit_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_midframe got outs=%b bit_cnt=%0d expected all 0",
                     {sample_valid, sample_i, sample_q, frame_err, overflow, fifo_level},
                     dut.bit_cnt);
        end
        sck = 1'b0; ss = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        ss = 1'b0;
        tick(4);
        send_bits(8'h12, 8);
        tick(4);
        checks++;
        if (sample_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup got valid=%b expected 1", sample_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sample_valid, sample_i, sample_q, frame_err, overflow, fifo_level} !== 10'b0) begin
            failures++;
            $display("FAIL reset_handshake got outs=%b expected all 0",
                     {sample_valid, sample_i, sample_q, frame_err, overflow, fifo_level});
        end
        sb.delete();
        ss = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        sample_ready = 1'b1;
        ss = 1'b0;
        tick(4);
        push_byte(8'h5A);
        send_bits(8'h5A, 8);
        wait_drain(100);
        ss = 1'b1;
        tick(4);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL reset_recover got pending=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_frame_error();
        test_overflow();
        test_ss_high();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
